// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the slice-serial adder.
package adder_pkg;
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder: {C, S} = x + y + c.
module ripple_carry_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c,
    output logic [3:0] S,
    output logic       C
);
    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        S        = '0;
        carry[0] = c;
        for (int i = 0; i < 4; i++) begin
            S[i]       = x[i] ^ y[i] ^ carry[i];
            carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
        C = carry[4];
    end
endmodule

// File: rtl/multiword_add_sequencer.sv
// WIDTH-bit add/subtract computed one 4-bit slice per clock through one shared
// ripple_carry_adder, LSB slice first, with the carry held in a register.
module multiword_add_sequencer
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] add_x, add_y, add_s;
    logic               add_c;

    ripple_carry_adder u_rca (
        .x (add_x),
        .y (add_y),
        .c (carry_q),
        .S (add_s),
        .C (add_c)
    );

    // Constant-index slice mux keeps part-selects static for every WIDTH.
    always_comb begin
        add_x = '0;
        add_y = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                add_x = a_q[i*SLICE_W +: SLICE_W];
                add_y = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDX_W'(i)) sum_d[i*SLICE_W +: SLICE_W] = add_s;
                end
                carry_d = add_c;
                if (idx_q == IDX_W'(NSLICE - 1)) begin
                    idx_d   = '0;
                    cout_d  = add_c;
                    // MSB carry-in is x^y^s at the top bit of the last slice.
                    ovf_d   = add_c ^ add_x[SLICE_W-1] ^ add_y[SLICE_W-1] ^ add_s[SLICE_W-1];
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule
